// File: rtl/gpu_host_mem_port.sv
// Host-bridge strobe capture, host/aux arbitration and in-order read return
// for GPU RAM port B.
module gpu_host_mem_port #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned RAM_WORDS   = 65536,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic              GPU_CLK,
    input  logic              reset,
    input  logic              host_wr_ena,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rData,
    output logic              host_rd_rdy,
    output logic              host_ovr,
    input  logic              aux_req,
    input  logic              aux_wr,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [7:0]        aux_wdata,
    output logic              aux_gnt,
    output logic [7:0]        aux_rData,
    output logic              aux_rd_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wena,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_AUX  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oob;
    } tag_t;

    localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);

    logic              wr_prev;
    logic              rd_prev;
    logic              wr_rise;
    logic              rd_rise;
    logic              capture;

    logic              pend_valid;
    logic              pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_wdata;

    logic              host_issue;
    logic              issue;
    logic              iss_wr;
    logic [ADDR_W-1:0] iss_addr;
    logic [7:0]        iss_wdata;
    owner_e            iss_owner;
    logic              iss_oob;
    tag_t              new_tag;

    tag_t              tag_pipe [RAM_LATENCY];
    tag_t              tag_out;
    logic [7:0]        ret_data;

    // A capture on the same edge as a pending issue replaces it: the old
    // request is dropped, never issued, so only the newest one reaches RAM.
    always_comb begin
        wr_rise    = host_wr_ena & ~wr_prev;
        rd_rise    = host_rd_req & ~rd_prev;
        capture    = wr_rise | rd_rise;
        aux_gnt    = aux_req & ~pend_valid;
        host_issue = pend_valid & ~capture;
        issue      = host_issue | aux_gnt;

        iss_wr    = aux_wr;
        iss_addr  = aux_addr;
        iss_wdata = aux_wdata;
        iss_owner = OWN_AUX;
        if (host_issue) begin
            iss_wr    = pend_wr;
            iss_addr  = pend_addr;
            iss_wdata = pend_wdata;
            iss_owner = OWN_HOST;
        end
        iss_oob = ({1'b0, iss_addr} >= RAM_LIMIT);

        new_tag.valid = issue & ~iss_wr;
        new_tag.owner = iss_owner;
        new_tag.oob   = iss_oob;

        ret_data = tag_out.oob ? 8'hFF : ram_rdata;
    end

    // Edge detectors reset high so a strobe held through reset is not an edge.
    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            wr_prev    <= 1'b1;
            rd_prev    <= 1'b1;
            pend_valid <= 1'b0;
            pend_wr    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            host_ovr   <= 1'b0;
        end else begin
            wr_prev  <= host_wr_ena;
            rd_prev  <= host_rd_req;
            host_ovr <= capture & pend_valid;
            if (capture) begin
                pend_valid <= 1'b1;
                pend_wr    <= wr_rise;
                pend_addr  <= host_addr;
                pend_wdata <= host_wdata;
            end else if (host_issue) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wena  <= 1'b0;
            ram_wdata <= '0;
        end else begin
            ram_wena <= issue & iss_wr & ~iss_oob;
            if (issue) begin
                ram_addr  <= iss_addr;
                ram_wdata <= iss_wdata;
            end
        end
    end

    // Tag leaves the pipe one edge before ram_rdata is sampled for return.
    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            tag_out <= '0;
        end else begin
            tag_pipe[0] <= new_tag;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            tag_out <= tag_pipe[RAM_LATENCY-1];
        end
    end

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            host_rData  <= '0;
            host_rd_rdy <= 1'b0;
            aux_rData   <= '0;
            aux_rd_rdy  <= 1'b0;
        end else begin
            host_rd_rdy <= tag_out.valid && (tag_out.owner == OWN_HOST);
            aux_rd_rdy  <= tag_out.valid && (tag_out.owner == OWN_AUX);
            if (tag_out.valid) begin
                if (tag_out.owner == OWN_HOST) begin
                    host_rData <= ret_data;
                end else begin
                    aux_rData <= ret_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_host_mem_port.sv
// Scoreboard bench for gpu_host_mem_port: stimulus pushes expected RAM writes,
// read returns, overrun pulses and probes; a negedge monitor pops and compares.
module tb_gpu_host_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_wr_ena;
    logic        host_rd_req;
    logic [19:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rData;
    logic        host_rd_rdy;
    logic        host_ovr;
    logic        aux_req;
    logic        aux_wr;
    logic [19:0] aux_addr;
    logic [7:0]  aux_wdata;
    logic        aux_gnt;
    logic [7:0]  aux_rData;
    logic        aux_rd_rdy;
    logic [19:0] ram_addr;
    logic        ram_wena;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    gpu_host_mem_port #(
        .ADDR_W     (20),
        .RAM_WORDS  (65536),
        .RAM_LATENCY(2)
    ) dut (
        .GPU_CLK    (clk),
        .reset      (rst),
        .host_wr_ena(host_wr_ena),
        .host_rd_req(host_rd_req),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rData (host_rData),
        .host_rd_rdy(host_rd_rdy),
        .host_ovr   (host_ovr),
        .aux_req    (aux_req),
        .aux_wr     (aux_wr),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (aux_gnt),
        .aux_rData  (aux_rData),
        .aux_rd_rdy (aux_rd_rdy),
        .ram_addr   (ram_addr),
        .ram_wena   (ram_wena),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with two-edge read latency
    logic [7:0] mem [0:65535];
    logic [7:0] rd_p0 = '0;
    logic [7:0] rd_p1 = '0;
    always @(posedge clk) begin
        rd_p0 <= mem[ram_addr[15:0]];
        rd_p1 <= rd_p0;
        if (ram_wena) mem[ram_addr[15:0]] <= ram_wdata;
    end
    assign ram_rdata = rd_p1;

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    // kind 0: aux_gnt, kind 1: all outputs concatenated, kind 2: ram_addr
    typedef struct {
        int unsigned cyc;
        int unsigned kind;
        logic [63:0] want;
    } probe_t;

    exp_t        wr_q[$];
    exp_t        host_q[$];
    exp_t        aux_q[$];
    int unsigned ovr_q[$];
    probe_t      probe_q[$];

    int  checks   = 0;
    int  failures = 0;
    bit  done     = 1'b0;

    exp_t        e;
    probe_t      p;
    int unsigned oc;
    logic [63:0] got;

    always @(negedge clk) begin
        if (ram_wena) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL ram_write_unexpected got addr=%h data=%h cyc=%0d want no write", ram_addr, ram_wdata, cyc);
            end else begin
                e = wr_q.pop_front();
                if (ram_addr !== e.addr || ram_wdata !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL ram_write got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             ram_addr, ram_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (host_rd_rdy) begin
            checks++;
            if (host_q.size() == 0) begin
                failures++;
                $display("FAIL host_rdy_unexpected got data=%h cyc=%0d want no ready", host_rData, cyc);
            end else begin
                e = host_q.pop_front();
                if (host_rData !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL host_read got data=%h cyc=%0d want data=%h cyc=%0d", host_rData, cyc, e.data, e.cyc);
                end
            end
        end
        if (aux_rd_rdy) begin
            checks++;
            if (aux_q.size() == 0) begin
                failures++;
                $display("FAIL aux_rdy_unexpected got data=%h cyc=%0d want no ready", aux_rData, cyc);
            end else begin
                e = aux_q.pop_front();
                if (aux_rData !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL aux_read got data=%h cyc=%0d want data=%h cyc=%0d", aux_rData, cyc, e.data, e.cyc);
                end
            end
        end
        if (host_ovr) begin
            checks++;
            if (ovr_q.size() == 0) begin
                failures++;
                $display("FAIL host_ovr_unexpected got cyc=%0d want no pulse", cyc);
            end else begin
                oc = ovr_q.pop_front();
                if (cyc != oc) begin
                    failures++;
                    $display("FAIL host_ovr got cyc=%0d want cyc=%0d", cyc, oc);
                end
            end
        end
        while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            case (p.kind)
                0: got = {63'd0, aux_gnt};
                1: got = {15'd0, host_rData, host_rd_rdy, host_ovr, aux_gnt, aux_rData,
                          aux_rd_rdy, ram_addr, ram_wena, ram_wdata};
                default: got = {44'd0, ram_addr};
            endcase
            checks++;
            if (got !== p.want || p.cyc != cyc) begin
                failures++;
                $display("FAIL probe_kind%0d got=%h cyc=%0d want=%h cyc=%0d", p.kind, got, cyc, p.want, p.cyc);
            end
        end
        if (done) begin
            checks++;
            if (wr_q.size() != 0) begin
                failures++;
                $display("FAIL ram_write_missing got %0d outstanding want 0", wr_q.size());
            end
            checks++;
            if (host_q.size() != 0) begin
                failures++;
                $display("FAIL host_read_missing got %0d outstanding want 0", host_q.size());
            end
            checks++;
            if (aux_q.size() != 0) begin
                failures++;
                $display("FAIL aux_read_missing got %0d outstanding want 0", aux_q.size());
            end
            checks++;
            if (ovr_q.size() != 0) begin
                failures++;
                $display("FAIL host_ovr_missing got %0d outstanding want 0", ovr_q.size());
            end
            checks++;
            if (probe_q.size() != 0) begin
                failures++;
                $display("FAIL probe_missing got %0d outstanding want 0", probe_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got no end of stimulus want finish");
        $fatal(1);
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic probe(input int unsigned c, input int unsigned k, input logic [63:0] w);
        probe_t t;
        t.cyc  = c;
        t.kind = k;
        t.want = w;
        probe_q.push_back(t);
    endtask

    task automatic exp_push(input int unsigned which, input logic [19:0] a,
                            input logic [7:0] d, input int unsigned c);
        exp_t t;
        t.addr = a;
        t.data = d;
        t.cyc  = c;
        if (which == 0) wr_q.push_back(t);
        else if (which == 1) host_q.push_back(t);
        else aux_q.push_back(t);
    endtask

    int unsigned m;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h5C;
        mem[16'h0020] = 8'h3A;
        mem[16'h0030] = 8'hC7;
        mem[16'h0040] = 8'h4D;

        rst         = 1'b1;
        host_wr_ena = 1'b0;
        host_rd_req = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        aux_req     = 1'b0;
        aux_wr      = 1'b0;
        aux_addr    = '0;
        aux_wdata   = '0;

        // reset state
        step(2);
        probe(cyc, 1, 64'd0);
        rst = 1'b0;
        step(2);

        // host write held two clocks: one RAM write
        m = cyc;
        host_addr = 20'h01234; host_wdata = 8'hA5; host_wr_ena = 1'b1;
        exp_push(0, 20'h01234, 8'hA5, m + 2);
        step(2);
        host_wr_ena = 1'b0;
        step(3);

        // host read: ready four clocks after capture
        m = cyc;
        host_addr = 20'h00010; host_rd_req = 1'b1;
        exp_push(1, 20'h00010, 8'h5C, m + 5);
        step(2);
        host_rd_req = 1'b0;
        step(6);

        // out-of-bounds write dropped, address still updates; read returns FF
        m = cyc;
        host_addr = 20'h10000; host_wdata = 8'h11; host_wr_ena = 1'b1;
        probe(m + 2, 2, 64'h10000);
        step(1);
        host_wr_ena = 1'b0;
        step(3);
        m = cyc;
        host_rd_req = 1'b1;
        exp_push(1, 20'h10000, 8'hFF, m + 5);
        step(1);
        host_rd_req = 1'b0;
        step(6);

        // contention: host first, aux granted the next clock
        m = cyc;
        host_addr = 20'h00030; host_rd_req = 1'b1;
        exp_push(1, 20'h00030, 8'hC7, m + 5);
        step(1);
        aux_req = 1'b1; aux_wr = 1'b0; aux_addr = 20'h00020;
        probe(m + 1, 0, 64'd0);
        step(1);
        probe(m + 2, 0, 64'd1);
        exp_push(2, 20'h00020, 8'h3A, m + 6);
        step(1);
        aux_req = 1'b0;
        host_rd_req = 1'b0;
        step(6);

        // both strobes rise together: write wins, read discarded
        m = cyc;
        host_addr = 20'h00060; host_wdata = 8'h99;
        host_wr_ena = 1'b1; host_rd_req = 1'b1;
        exp_push(0, 20'h00060, 8'h99, m + 2);
        step(1);
        host_wr_ena = 1'b0; host_rd_req = 1'b0;
        step(5);

        // overrun while aux keeps requesting: only the newer request issues
        m = cyc;
        aux_req = 1'b1; aux_wr = 1'b0; aux_addr = 20'h00020;
        host_addr = 20'h00040; host_rd_req = 1'b1;
        exp_push(2, 20'h00020, 8'h3A, m + 4);
        step(1);
        host_rd_req = 1'b0;
        host_addr = 20'h00050; host_wdata = 8'h77; host_wr_ena = 1'b1;
        probe(m + 1, 0, 64'd0);
        ovr_q.push_back(m + 2);
        exp_push(0, 20'h00050, 8'h77, m + 3);
        step(1);
        host_wr_ena = 1'b0;
        step(1);
        probe(m + 3, 0, 64'd1);
        exp_push(2, 20'h00020, 8'h3A, m + 7);
        step(1);
        aux_req = 1'b0;
        step(6);

        // reset with two reads in flight and host_rd_req held through release
        m = cyc;
        host_addr = 20'h00010; host_rd_req = 1'b1;
        step(1);
        aux_req = 1'b1; aux_addr = 20'h00020;
        step(2);
        aux_req = 1'b0;
        rst = 1'b1;
        probe(m + 3, 1, 64'd0);
        step(2);
        rst = 1'b0;
        probe(m + 5, 1, 64'd0);
        probe(m + 8, 1, 64'd0);
        step(5);
        host_rd_req = 1'b0;
        step(4);
        done = 1'b1;
    end

endmodule
